if_stage: RTL

Instruction-fetch stage and IF/ID pipeline register for the 5-stage RV32I core. Holds the PC, presents it to the asynchronous-read instruction memory, and registers the fetched word with its PC and PC+4 into IF/ID. The ID-stage decoder consumes `id_ir` and `id_pc4` feeds the PC+4 write-back path. Accepts a load-use stall from the hazard unit and a control-transfer redirect from EX.

---
 rtl/if_stage.sv | 98 +++++++++
 1 files changed

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
//  Module   : if_stage
//  Purpose  : Instruction-fetch stage and IF/ID pipeline register of the
//             5-stage RV32I core. Holds the PC, drives it to the
//             asynchronous-read instruction memory and captures the fetched
//             word together with its PC and PC+4 into IF/ID.
//  Ports    : clk, rst          - core clock, async active-high reset
//             stall             - hazard unit: hold PC and IF/ID
//             redirect,
//             redirect_pc       - EX stage control transfer and its target
//             imem_addr/data    - instruction memory address / read word
//             id_ir, id_pc,
//             id_pc4, id_valid  - IF/ID register contents
//             fetch_count       - valid instructions loaded into IF/ID
//  Revision : 1.0 - initial release
// ============================================================================
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] id_ir,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  output logic        id_valid,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] idpc_q, idpc_d;
  logic [31:0] idpc4_q, idpc4_d;
  logic        valid_q, valid_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  // Redirect outranks stall: a stalled instruction sitting in IF/ID is on the
  // wrong path once EX resolves a control transfer, so it is replaced by a
  // bubble rather than held.
  always_comb begin
    pc_d    = pc_q;
    ir_d    = ir_q;
    idpc_d  = idpc_q;
    idpc4_d = idpc4_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (redirect) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      ir_d    = NOP_INSN;
      idpc_d  = 32'd0;
      idpc4_d = 32'd0;
      valid_d = 1'b0;
    end else if (!stall) begin
      pc_d    = pc_plus4;
      ir_d    = imem_data;
      idpc_d  = pc_q;
      idpc4_d = pc_plus4;
      valid_d = 1'b1;
      cnt_d   = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      ir_q    <= NOP_INSN;
      idpc_q  <= 32'd0;
      idpc4_q <= 32'd0;
      valid_q <= 1'b0;
      cnt_q   <= 32'd0;
    end else begin
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      idpc_q  <= idpc_d;
      idpc4_q <= idpc4_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_addr   = pc_q;
  assign id_ir       = ir_q;
  assign id_pc       = idpc_q;
  assign id_pc4      = idpc4_q;
  assign id_valid    = valid_q;
  assign fetch_count = cnt_q;

endmodule
`default_nettype wire
